// File: rtl/audio_pkg.sv
// audio_pkg: definitions shared by the I2S DAC transmitter and the ADC receiver.
//   SAMPLE_BITS_DEF : default bits captured per channel.
//   stereo_t        : one stereo frame {left, right} at the default width.
//   i2s_state_t     : slot-tracking FSM states.
package audio_pkg;

    localparam int SAMPLE_BITS_DEF = 16;

    typedef struct packed {
        logic [SAMPLE_BITS_DEF-1:0] left;
        logic [SAMPLE_BITS_DEF-1:0] right;
    } stereo_t;

    typedef enum logic [1:0] {
        I2S_IDLE      = 2'd0,
        I2S_WAIT_LEFT = 2'd1,
        I2S_CAP_LEFT  = 2'd2,
        I2S_CAP_RIGHT = 2'd3
    } i2s_state_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous show-ahead FIFO with count-based full/empty.
//   clk32, rst      : system clock, async active-high reset
//   flush           : synchronous empty (stored words are left in place)
//   push, push_data : write side; push is ignored when full with no pop
//   full            : DEPTH entries stored
//   pop             : consume head (ignored when empty)
//   valid, pop_data : head entry, presented before it is popped
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk32,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] pop_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign valid    = (count != '0);
    assign pop_data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    // a push that coincides with a pop.
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: I2S receiver for the codec ADC path. Oversamples BCLK/LRCK/DATA
// on clk32, deserialises 16-bit stereo frames and queues them for the SoC.
//   clk32, rst                 : system clock, async active-high reset
//   bclk_i, lrck_i, adcdat_i   : codec pins (asynchronous); lrck 0 = left
//   enable_i                   : capture enable; low idles and flushes
//   sample_valid_o/ready_i     : head handshake, pop on valid & ready
//   left_o, right_o            : head stereo sample
//   overflow_o, frame_err_o    : sticky flags, cleared by flags_clr_i
//
// state      | meaning
// IDLE       | capture disabled
// WAIT_LEFT  | enabled, waiting for LRCK 1->0 to align on a left slot
// CAP_LEFT   | shifting left-slot bits
// CAP_RIGHT  | shifting right-slot bits
module i2s_adc_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk32,
    input  logic                   rst,
    input  logic                   bclk_i,
    input  logic                   lrck_i,
    input  logic                   adcdat_i,
    input  logic                   enable_i,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic [SAMPLE_BITS-1:0] left_o,
    output logic [SAMPLE_BITS-1:0] right_o,
    output logic                   overflow_o,
    output logic                   frame_err_o,
    input  logic                   flags_clr_i
);

    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_BITS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLE_BITS);

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
    logic                   bclk_prev, bit_stb, lr_s, dat_s;

    i2s_state_t             state;
    logic                   lr_prev;
    logic [CW-1:0]          cnt;
    logic [SAMPLE_BITS-1:0] shreg, hold_left, word_next;
    logic                   left_ok;

    logic                   lr_change, in_cap, slot_short;
    logic                   push, fifo_full, err_set, ovf_set;

    // LRCK and data are registered alongside the strobe so that all three
    // describe the same BCLK rise.
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            bit_stb   <= 1'b0;
            lr_s      <= 1'b0;
            dat_s     <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_i};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_i};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat_i};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
            bit_stb   <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
            lr_s      <= lrck_sync[SYNC_STAGES-1];
            dat_s     <= dat_sync[SYNC_STAGES-1];
        end
    end

    assign lr_change  = lr_s ^ lr_prev;
    assign word_next  = {shreg[SAMPLE_BITS-2:0], dat_s};
    assign in_cap     = (state == I2S_CAP_LEFT) || (state == I2S_CAP_RIGHT);
    assign slot_short = (cnt < CNT_FULL);

    // Push on the strobe carrying the last right bit so the frame is
    // visible at the FIFO head on the following cycle.
    assign push    = enable_i & bit_stb & (state == I2S_CAP_RIGHT) & ~lr_change
                   & (cnt == CNT_LAST) & left_ok;
    assign err_set = enable_i & bit_stb & in_cap & lr_change & slot_short;
    assign ovf_set = push & fifo_full & ~(sample_valid_o & sample_ready_i);

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            state     <= I2S_IDLE;
            lr_prev   <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            hold_left <= '0;
            left_ok   <= 1'b0;
        end else begin
            // LRCK history is tracked even while idle so that enabling in
            // the middle of a slot never looks like a fresh edge.
            if (bit_stb) begin
                lr_prev <= lr_s;
            end
            if (!enable_i) begin
                state     <= I2S_IDLE;
                cnt       <= '0;
                shreg     <= '0;
                hold_left <= '0;
                left_ok   <= 1'b0;
            end else begin
                case (state)
                    I2S_IDLE: state <= I2S_WAIT_LEFT;
                    I2S_WAIT_LEFT: begin
                        if (bit_stb && lr_change && !lr_s) begin
                            state <= I2S_CAP_LEFT;
                            cnt   <= '0;
                        end
                    end
                    I2S_CAP_LEFT, I2S_CAP_RIGHT: begin
                        if (bit_stb && lr_change) begin
                            // This strobe is the I2S delay bit of the new slot.
                            cnt   <= '0;
                            shreg <= '0;
                            state <= lr_s ? I2S_CAP_RIGHT : I2S_CAP_LEFT;
                            if (slot_short) begin
                                left_ok <= 1'b0;
                            end
                        end else if (bit_stb && slot_short) begin
                            shreg <= word_next;
                            cnt   <= cnt + 1'b1;
                            if (cnt == CNT_LAST) begin
                                if (state == I2S_CAP_LEFT) begin
                                    hold_left <= word_next;
                                    left_ok   <= 1'b1;
                                end else begin
                                    left_ok   <= 1'b0;
                                end
                            end
                        end
                    end
                    default: state <= I2S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (flags_clr_i) begin
                overflow_o <= 1'b0;
            end
            if (err_set) begin
                frame_err_o <= 1'b1;
            end else if (flags_clr_i) begin
                frame_err_o <= 1'b0;
            end
        end
    end

    sample_fifo #(
        .WIDTH (2 * SAMPLE_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk32     (clk32),
        .rst       (rst),
        .flush     (~enable_i),
        .push      (push),
        .push_data ({hold_left, word_next}),
        .full      (fifo_full),
        .pop       (sample_ready_i),
        .valid     (sample_valid_o),
        .pop_data  ({left_o, right_o})
    );

endmodule

// File: tb/tb_i2s_adc_rx.sv
`timescale 1ns/1ps
module tb_i2s_adc_rx;
    import audio_pkg::*;

    localparam int SB    = 16;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HALF  = 6;

    logic          clk32 = 1'b0;
    logic          rst = 1'b1;
    logic          bclk_i = 1'b0, lrck_i = 1'b1, adcdat_i = 1'b0;
    logic          enable_i = 1'b0, sample_ready_i = 1'b0, flags_clr_i = 1'b0;
    logic          sample_valid_o, overflow_o, frame_err_o;
    logic [SB-1:0] left_o, right_o;

    always #5 clk32 = ~clk32;

    i2s_adc_rx #(.SAMPLE_BITS(SB), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk32          (clk32),
        .rst            (rst),
        .bclk_i         (bclk_i),
        .lrck_i         (lrck_i),
        .adcdat_i       (adcdat_i),
        .enable_i       (enable_i),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .left_o         (left_o),
        .right_o        (right_o),
        .overflow_o     (overflow_o),
        .frame_err_o    (frame_err_o),
        .flags_clr_i    (flags_clr_i)
    );

    int      n_cmp = 0, n_fail = 0;
    int      cyc = 0, last_rise = 0, data_end = 0, valid_rise = -1;
    logic    prev_valid = 1'b0;
    stereo_t exp_q[$];
    logic    model_ovf;

    always @(posedge clk32) cyc <= cyc + 1;

    always @(negedge clk32) begin
        if (sample_valid_o && !prev_valid) valid_rise = cyc;
        prev_valid = sample_valid_o;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One BCLK period: data/LRCK change on the falling edge, 6 cycles per phase.
    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk32);
        bclk_i = 1'b0; lrck_i = lr; adcdat_i = d;
        repeat (HALF) @(negedge clk32);
        bclk_i = 1'b1; last_rise = cyc;
        repeat (HALF - 1) @(negedge clk32);
    endtask

    // I2S slot: one delay bit, nbits MSB first, then pad don't-care bits.
    task automatic send_slot(input logic lr, input logic [SB-1:0] w, input int nbits, input int pad);
        send_bit(lr, 1'($urandom));
        for (int i = 0; i < nbits; i++) send_bit(lr, w[SB-1-i]);
        data_end = last_rise;
        for (int i = 0; i < pad; i++) send_bit(lr, 1'($urandom));
    endtask

    task automatic send_frame(input logic [SB-1:0] l, input logic [SB-1:0] r);
        send_slot(1'b0, l, SB, $urandom_range(0, 2));
        send_slot(1'b1, r, SB, $urandom_range(0, 2));
    endtask

    task automatic preamble();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'($urandom));
    endtask

    task automatic settle();
        repeat (8) @(negedge clk32);
    endtask

    task automatic pulse_clr();
        @(negedge clk32); flags_clr_i = 1'b1;
        @(negedge clk32); flags_clr_i = 1'b0;
    endtask

    task automatic model_push(input logic [SB-1:0] l, input logic [SB-1:0] r);
        if (exp_q.size() < DEPTH) exp_q.push_back(stereo_t'{left: l, right: r});
        else model_ovf = 1'b1;
    endtask

    // Waits (bounded) for a head entry, captures it and pops it.
    task automatic pop_one(output logic ok, output logic [SB-1:0] l, output logic [SB-1:0] r);
        ok = 1'b0; l = '0; r = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk32);
            if (sample_valid_o) ok = 1'b1;
        end
        if (ok) begin
            l = left_o; r = right_o;
            sample_ready_i = 1'b1;
            @(negedge clk32);
            sample_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk32);
            bclk_i = 1'($urandom); lrck_i = 1'($urandom); adcdat_i = 1'($urandom);
            enable_i = 1'($urandom); sample_ready_i = 1'($urandom); flags_clr_i = 1'($urandom);
        end
        n_cmp += 5;
        if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sample_valid_o); end
        if (left_o !== '0) begin n_fail++; $display("FAIL reset_left: got %h want 0", left_o); end
        if (right_o !== '0) begin n_fail++; $display("FAIL reset_right: got %h want 0", right_o); end
        if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        @(negedge clk32);
        bclk_i = 1'b0; lrck_i = 1'b1; enable_i = 1'b0; sample_ready_i = 1'b0; flags_clr_i = 1'b0;
        rst = 1'b0;
        settle();
        enable_i = 1'b1;
        preamble();
        send_slot(1'b0, 16'($urandom), SB, 1);
        settle();
        n_cmp++;
        if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL left_only_valid: got %b want 0", sample_valid_o); end
        enable_i = 1'b0;
        settle();
    endtask

    task automatic test_single_frame();
        logic ok; logic [SB-1:0] l, r;
        enable_i = 1'b1;
        preamble();
        valid_rise = -1;
        send_frame(16'h8001, 16'h7FFE);
        settle();
        n_cmp++;
        if (valid_rise - data_end !== SYNC + 2) begin
            n_fail++; $display("FAIL push_latency: got %0d cycles want %0d", valid_rise - data_end, SYNC + 2);
        end
        pop_one(ok, l, r);
        n_cmp += 2;
        if (!ok || l !== 16'h8001) begin n_fail++; $display("FAIL single_left: got %h (ok=%b) want 8001", l, ok); end
        if (!ok || r !== 16'h7FFE) begin n_fail++; $display("FAIL single_right: got %h (ok=%b) want 7ffe", r, ok); end
        @(negedge clk32);
        n_cmp++;
        if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", sample_valid_o); end
    endtask

    task automatic test_overflow();
        logic ok; logic [SB-1:0] l, r;
        stereo_t e;
        exp_q.delete(); model_ovf = 1'b0;
        pulse_clr();
        preamble();
        for (int k = 1; k <= 5; k++) begin
            model_push(16'(k), 16'(k + 256));
            send_frame(16'(k), 16'(k + 256));
            settle();
            if (k >= 4) begin
                n_cmp++;
                if (overflow_o !== model_ovf) begin
                    n_fail++; $display("FAIL ovf_after_%0d: got %b want %b", k, overflow_o, model_ovf);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_one(ok, l, r);
            n_cmp++;
            if (!ok || l !== e.left || r !== e.right) begin
                n_fail++; $display("FAIL ovf_pop: got %h/%h (ok=%b) want %h/%h", l, r, ok, e.left, e.right);
            end
        end
        @(negedge clk32);
        n_cmp++;
        if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", sample_valid_o); end
        pulse_clr();
        n_cmp++;
        if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow_o); end
    endtask

    task automatic test_truncated();
        logic ok; logic [SB-1:0] l, r;
        pulse_clr();
        preamble();
        send_slot(1'b0, 16'($urandom), 10, 0);
        send_slot(1'b1, 16'($urandom), SB, 1);
        settle();
        n_cmp += 2;
        if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL trunc_ferr: got %b want 1", frame_err_o); end
        if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL trunc_nopush: got %b want 0", sample_valid_o); end
        send_frame(16'h1234, 16'h5678);
        settle();
        pop_one(ok, l, r);
        n_cmp++;
        if (!ok || l !== 16'h1234 || r !== 16'h5678) begin
            n_fail++; $display("FAIL trunc_next: got %h/%h (ok=%b) want 1234/5678", l, r, ok);
        end
        pulse_clr();
        n_cmp++;
        if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", frame_err_o); end
    endtask

    task automatic test_enable_mid_right();
        logic ok; logic [SB-1:0] l, r;
        stereo_t a, b;
        enable_i = 1'b1;
        preamble();
        send_frame(16'($urandom), 16'($urandom));
        settle();
        enable_i = 1'b0;
        settle();
        n_cmp++;
        if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL disable_flush: got %b want 0", sample_valid_o); end
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'($urandom));
        enable_i = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom));
        a = stereo_t'($urandom);
        b = stereo_t'($urandom);
        send_frame(a.left, a.right);
        send_frame(b.left, b.right);
        settle();
        pop_one(ok, l, r);
        n_cmp++;
        if (!ok || l !== a.left || r !== a.right) begin
            n_fail++; $display("FAIL en_first: got %h/%h (ok=%b) want %h/%h", l, r, ok, a.left, a.right);
        end
        pop_one(ok, l, r);
        n_cmp++;
        if (!ok || l !== b.left || r !== b.right) begin
            n_fail++; $display("FAIL en_second: got %h/%h (ok=%b) want %h/%h", l, r, ok, b.left, b.right);
        end
    endtask

    task automatic test_reset_mid();
        logic ok; logic [SB-1:0] l, r;
        stereo_t c;
        enable_i = 1'b1;
        preamble();
        send_frame(16'($urandom), 16'($urandom));
        send_slot(1'b0, 16'($urandom), 8, 0);
        @(negedge clk32); rst = 1'b1;
        repeat (3) @(negedge clk32);
        n_cmp += 3;
        if (sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", sample_valid_o); end
        if (left_o !== '0) begin n_fail++; $display("FAIL rstmid_left: got %h want 0", left_o); end
        if (right_o !== '0) begin n_fail++; $display("FAIL rstmid_right: got %h want 0", right_o); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'($urandom));
        send_slot(1'b1, 16'($urandom), SB, 1);
        c = stereo_t'($urandom);
        send_frame(c.left, c.right);
        settle();
        pop_one(ok, l, r);
        n_cmp += 2;
        if (!ok || l !== c.left || r !== c.right) begin
            n_fail++; $display("FAIL rstmid_resume: got %h/%h (ok=%b) want %h/%h", l, r, ok, c.left, c.right);
        end
        if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ferr: got %b want 0", frame_err_o); end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        stereo_t e;
        exp_q.delete();
        enable_i = 1'b1;
        preamble();
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    e = stereo_t'($urandom);
                    exp_q.push_back(e);
                    send_frame(e.left, e.right);
                end
            end
            begin
                stereo_t h;
                for (int t = 0; t < 20000 && got < 6; t++) begin
                    @(negedge clk32);
                    sample_ready_i = 1'($urandom);
                    if (sample_valid_o && sample_ready_i) begin
                        h = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                        got++;
                        n_cmp++;
                        if (left_o !== h.left || right_o !== h.right) begin
                            n_fail++; $display("FAIL b2b_%0d: got %h/%h want %h/%h", got, left_o, right_o, h.left, h.right);
                        end
                    end
                end
                @(negedge clk32);
                sample_ready_i = 1'b0;
            end
        join
        n_cmp++;
        if (got != 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", got); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_truncated();
        test_enable_mid_right();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
